// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 valid/ready stream mux with round-robin grant
// and a single registered output stage.
module rr_stream_mux #(
  parameter int BUS_WIDTH = 32,
  parameter int NUM_IN    = 4,
  localparam int SEL_W    = $clog2(NUM_IN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN-1:0]           in_valid,
  input  logic [NUM_IN*BUS_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]           in_ready,
  output logic                        out_valid,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready
);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] grant;
  logic             found;
  logic             load;
  logic             accept;

  // Wrap is modulo NUM_IN so non-power-of-2 counts never reach ghost slots.
  function automatic logic [SEL_W-1:0] rr_idx(
    input logic [SEL_W-1:0] p,
    input int               k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return s[SEL_W-1:0];
  endfunction

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (!found && in_valid[rr_idx(last_grant, k)]) begin
        grant = rr_idx(last_grant, k);
        found = 1'b1;
      end
    end
  end

  assign load   = !out_valid || out_ready;
  assign accept = found && load && !rst;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SEL_W'(NUM_IN - 1);
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[grant*BUS_WIDTH +: BUS_WIDTH];
      out_sel    <= grant;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed and random checks of rr_stream_mux
// against a queue-free round-robin reference model.
module tb_rr_stream_mux;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  logic           rst3;
  logic [2:0]     v3;
  logic [3*W-1:0] d3;
  logic [2:0]     r3;
  logic           ov3;
  logic [W-1:0]   od3;
  logic [1:0]     os3;
  logic           ordy3;

  rr_stream_mux #(.BUS_WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  rr_stream_mux #(.BUS_WIDTH(W), .NUM_IN(3)) dut3 (
    .clk(clk), .rst(rst3),
    .in_valid(v3), .in_data(d3), .in_ready(r3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3),
    .out_ready(ordy3)
  );

  int n_checks = 0;
  int n_errors = 0;

  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = N - 1;
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
  endtask

  task automatic cycle();
    int         g;
    bit         ld;
    logic [N-1:0] er;
    #1;
    ld = !m_valid || out_ready;
    g  = pick(in_valid, m_ptr);
    er = '0;
    if (!rst && ld && g >= 0) er[g] = 1'b1;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_sel", out_sel, m_sel);
    @(posedge clk);
    if (rst) model_reset();
    else if (ld && g >= 0) begin
      m_valid = 1;
      m_data  = in_data[g*W +: W];
      m_sel   = g;
      m_ptr   = g;
    end else if (out_ready) m_valid = 0;
    #1;
  endtask

  task automatic fixed_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA000_0000 | i;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; in_valid = '1; out_ready = 1; fixed_data();
    rst3 = 1; v3 = '1; ordy3 = 1;
    for (int i = 0; i < 3; i++) d3[i*W +: W] = 32'hA000_0000 | i;
    @(posedge clk); #1;
    model_reset();

    // reset: all valid and ready, nothing accepted
    cycle(); cycle();
    check("rst_ready", in_ready, 4'b0000);
    check("rst_valid", out_valid, 1'b0);

    // fairness
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("fair_sel", out_sel, i % 4);
      check("fair_data", out_data, 32'hA000_0000 | (i % 4));
    end

    // sparse requests, pointer holds through idle
    in_valid = 4'b0100; cycle();
    check("sparse_sel2", out_sel, 2);
    in_valid = 4'b0000; cycle();
    check("idle_drop", out_valid, 1'b0);
    cycle(); cycle();
    in_valid = 4'b1001; cycle();
    check("sparse_sel3", out_sel, 3);
    in_valid = 4'b0001; cycle();
    check("sparse_sel0", out_sel, 0);

    // back-pressure
    in_valid = '1; cycle();
    check("bp_pre_sel", out_sel, 1);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_ready", in_ready, 4'b0000);
      check("bp_sel", out_sel, 1);
    end
    out_ready = 1; cycle();
    check("bp_resume", out_sel, 2);

    // reset while stalled
    out_ready = 0; rst = 1; cycle();
    check("mid_rst_valid", out_valid, 1'b0);
    rst = 0; out_ready = 1; cycle();
    check("mid_rst_first", out_sel, 0);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      cycle();
    end

    // NUM_IN=3 wraps modulo 3
    rst3 = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("n3_ready", r3, 3'b001 << (i % 3));
      @(posedge clk); #1;
      check("n3_valid", ov3, 1'b1);
      check("n3_sel", os3, i % 3);
      check("n3_data", od3, 32'hA000_0000 | (i % 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-to-1 stream multiplexer with round-robin arbitration, valid/ready handshakes on every port, and one registered output stage. It generalises the 2:1 bus select to NUM_IN sources. Each source presents its own request, and the block picks which one to forward. It sits wherever several producers share one consumer, for example instruction fetch and load/store sharing one memory request bus. It sustains one transfer per cycle.

## Interface
- BUS_WIDTH, default 32: data width per channel.
- NUM_IN, default 4: number of input channels; legal range 2..16.
- SEL_W, derived as $clog2(NUM_IN): width of the source index; not overridable.
- clk  input  1: single clock; all state updates on rising edge.
- rst  input  1: reset; synchronous and active-high.
- in_valid  input  NUM_IN: bit i high means channel i presents data.
- in_data  input  NUM_IN*BUS_WIDTH: flattened; channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- in_ready  output  NUM_IN: one-hot or zero; bit i high means channel i is accepted this cycle.
- out_valid  output  1: output register holds a valid word.
- out_data  output  BUS_WIDTH: registered data.
- out_sel  output  SEL_W: index of the channel that supplied out_data.
- out_ready  input  1: consumer accepts out_data this cycle.

## Operation
- State:
  - Output register: out_valid, out_data, out_sel.
  - Round-robin pointer last_grant, SEL_W bits.
- Load enable `load = !out_valid || out_ready`. When this is high, the output register can take a new word this cycle.
- Arbitration is combinational each cycle:
  - Search order is last_grant+1, last_grant+2, … wrapping modulo NUM_IN, ending at last_grant.
  - The first index with in_valid high is the grant g.
- in_ready[g] = load; all other in_ready bits are 0. When load is 0, every in_ready bit is 0.
- Accept occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data ← channel g data.
  - out_sel ← g.
  - out_valid ← 1.
  - last_grant ← g.
- Drain with no accept: if out_ready is high and no channel is valid, out_valid ← 0 on the next edge. out_data and out_sel hold their last values.
- Stall: if out_valid && !out_ready, the output register and last_grant hold, and in_ready stays all-zero.
- The pointer advances only on an accept. An idle cycle never moves it.
- Sources follow valid/ready rules: once in_valid is raised, data is held until accepted. The block does not depend on this, because the grant is recomputed every cycle with no lock.
- Channel indices at or above NUM_IN never exist, and wrap uses modulo NUM_IN, not 2^SEL_W. This matters for non-power-of-2 NUM_IN.

## Timing
- Reset values while rst is high and after the edge:
  - out_valid = 0, out_data = 0, out_sel = 0.
  - last_grant = NUM_IN-1, so input 0 has first priority after reset.
  - in_ready = all 0 while rst is high. Inputs are ignored during reset.
- Latency: accept in cycle n puts out_valid and data on the output in cycle n+1.
- Throughput: one word per cycle while out_ready is held high and any input is valid.
- in_ready depends combinationally on out_ready, out_valid, in_valid and last_grant. There is no combinational path from in_data to any output.
- Simultaneous drain and load: with out_valid=1, out_ready=1 and some input valid, the old word leaves and the new word loads on the same edge. out_valid stays 1.
- Reset mid-transfer: an in-flight word in the register is discarded, and accepts in the reset cycle are suppressed.
- Fairness: with all NUM_IN inputs valid continuously and out_ready high, each channel is granted exactly once in every NUM_IN consecutive accepts.

## Test plan
Parameters for all scenarios: NUM_IN=4, BUS_WIDTH=32; channel i data = 0xA000_000i.
1. Reset check: hold rst for 2 cycles with all in_valid=1 and out_ready=1 -> in_ready=0000 throughout, out_valid=0, out_data=0, out_sel=0. The first accept after release grants channel 0.
2. Round-robin fairness: all in_valid=1 and out_ready=1 for 8 cycles after reset -> out_sel sequence 0,1,2,3,0,1,2,3 on consecutive cycles, out_valid=1 from the cycle after the first accept, and out_data matches out_sel.
3. Sparse requests with pointer hold:
   - Only channel 2 valid for one cycle -> out_sel=2.
   - Then 3 idle cycles -> out_valid drops after 1 cycle.
   - Then channels 0 and 3 valid -> channel 3 is granted first, then 0.
4. Back-pressure: out_ready=0 with out_valid=1 and all inputs valid for 5 cycles -> in_ready=0000, and out_data/out_sel stable. Raising out_ready resumes with the next index after the held out_sel on the following edge.
5. Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> out_valid=0 and last_grant=3 after the edge. The held word is never observed as accepted.
6. Non-power-of-2 case: NUM_IN=3 with all inputs valid -> out_sel 0,1,2,0,1,2. Index 3 never appears.
